// File: rtl/frac_lut_pkg.sv
// Shared types and image-layout helpers for the fracturable LUT.
package frac_lut_pkg;

  typedef enum logic [1:0] {IDLE, LOADING, LOADED} cfg_state_t;

  localparam int FRAC_OFFSET = 0;
  localparam int REG_OFFSET  = 1;

  // Mode bits sit directly above the truth table in the image.
  function automatic int frac_bit(input int mem_size);
    return mem_size + FRAC_OFFSET;
  endfunction

  function automatic int reg_bit(input int mem_size);
    return mem_size + REG_OFFSET;
  endfunction

endpackage

// File: rtl/lut_config_chain.sv
// Scan-chain shadow register and frame-counting loader FSM.
module lut_config_chain
  import frac_lut_pkg::*;
#(
  parameter int FRAME_WIDTH = 1,
  parameter int CONFIG_BITS = 18,
  parameter int NUM_FRAMES  = 18,
  parameter int IMAGE_BITS  = 18
) (
  input  logic                   config_clk,
  input  logic                   reset,
  input  logic                   config_en,
  input  logic [FRAME_WIDTH-1:0] config_in,
  input  logic                   config_commit,
  output logic [FRAME_WIDTH-1:0] config_out,
  output logic                   config_done,
  output logic                   config_loaded,
  output logic                   commit,
  output logic [IMAGE_BITS-1:0]  image
);

  localparam int CW = $clog2(NUM_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_FRAMES - 1);

  cfg_state_t              state, next_state;
  logic [CW-1:0]           cnt, next_cnt;
  logic                    done_next;
  logic [CONFIG_BITS-1:0]  shadow, shadow_next;

  generate
    if (CONFIG_BITS > FRAME_WIDTH) begin : g_shift
      assign shadow_next = {shadow[CONFIG_BITS-FRAME_WIDTH-1:0], config_in};
    end else begin : g_single
      assign shadow_next = config_in;
    end
  endgenerate

  // A config_en outside LOADING always begins a fresh image, abandoning any held one.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    done_next  = 1'b0;
    commit     = 1'b0;
    case (state)
      LOADING: begin
        if (config_en) begin
          if (cnt == LAST) begin
            next_state = LOADED;
            next_cnt   = '0;
            done_next  = 1'b1;
          end else begin
            next_cnt = cnt + CW'(1);
          end
        end
      end
      LOADED: begin
        commit = config_commit;
        if (config_commit) next_state = IDLE;
      end
      default: ;
    endcase
    if (config_en && state != LOADING) begin
      if (NUM_FRAMES == 1) begin
        next_state = LOADED;
        next_cnt   = '0;
        done_next  = 1'b1;
      end else begin
        next_state = LOADING;
        next_cnt   = CW'(1);
      end
    end
  end

  always_ff @(posedge config_clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      config_done <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      config_done <= done_next;
      if (config_en) shadow <= shadow_next;
    end
  end

  assign config_out    = shadow[CONFIG_BITS-1 -: FRAME_WIDTH];
  assign config_loaded = (state == LOADED);
  assign image         = shadow[IMAGE_BITS-1:0];

endmodule

// File: rtl/frac_lut.sv
// Double-buffered K-input LUT, fracturable into two (K-1)-input LUTs, optional registered outputs.
module frac_lut
  import frac_lut_pkg::*;
#(
  parameter int INPUTS      = 4,
  parameter int FRAME_WIDTH = 1,
  parameter int MEM_SIZE    = 1 << INPUTS,
  parameter int CONFIG_BITS = ((MEM_SIZE + 2 + FRAME_WIDTH - 1) / FRAME_WIDTH) * FRAME_WIDTH,
  parameter int NUM_FRAMES  = CONFIG_BITS / FRAME_WIDTH
) (
  input  logic                   config_clk,
  input  logic                   reset,
  input  logic [INPUTS-1:0]      s,
  input  logic                   ce,
  output logic                   z0,
  output logic                   z1,
  input  logic                   config_en,
  input  logic [FRAME_WIDTH-1:0] config_in,
  output logic [FRAME_WIDTH-1:0] config_out,
  input  logic                   config_commit,
  output logic                   config_done,
  output logic                   config_loaded
);

  localparam int IMAGE_BITS = MEM_SIZE + 2;
  localparam int FRAC_BIT   = frac_bit(MEM_SIZE);
  localparam int REG_BIT    = reg_bit(MEM_SIZE);

  logic [IMAGE_BITS-1:0] image, active;
  logic                  commit;
  logic [MEM_SIZE-1:0]   m;
  logic [INPUTS-2:0]     l;
  logic                  frac, reg_mode, f0, f1, q0, q1;

  lut_config_chain #(
    .FRAME_WIDTH(FRAME_WIDTH),
    .CONFIG_BITS(CONFIG_BITS),
    .NUM_FRAMES (NUM_FRAMES),
    .IMAGE_BITS (IMAGE_BITS)
  ) u_chain (
    .config_clk   (config_clk),
    .reset        (reset),
    .config_en    (config_en),
    .config_in    (config_in),
    .config_commit(config_commit),
    .config_out   (config_out),
    .config_done  (config_done),
    .config_loaded(config_loaded),
    .commit       (commit),
    .image        (image)
  );

  // The commit copies the shadow as it stood before any same-cycle shift.
  always_ff @(posedge config_clk) begin
    if (!reset)      active <= '0;
    else if (commit) active <= image;
  end

  assign m        = active[MEM_SIZE-1:0];
  assign frac     = active[FRAC_BIT];
  assign reg_mode = active[REG_BIT];
  assign l        = s[INPUTS-2:0];

  always_comb begin
    f0 = m[s];
    f1 = 1'b0;
    if (frac) begin
      f0 = m[{1'b0, l}];
      f1 = m[{1'b1, l}];
    end
  end

  always_ff @(posedge config_clk) begin
    if (!reset) begin
      q0 <= 1'b0;
      q1 <= 1'b0;
    end else if (ce) begin
      q0 <= f0;
      q1 <= f1;
    end
  end

  assign z0 = reg_mode ? q0 : f0;
  assign z1 = reg_mode ? q1 : f1;

endmodule

// File: doc/frac_lut.md
# frac_lut

Fracturable, double-buffered K-input LUT for the fabric tile. Configuration shifts in over a frame-wide scan chain into a shadow image. A one-cycle commit copies that image into the active truth table, so the live function never glitches while a new image loads. Mode bits in the image select between one K-input LUT and two (K-1)-input LUTs on shared inputs, and between combinational and registered outputs.

## Interface
- INPUTS, 4, LUT input count K (≥2)
- FRAME_WIDTH, 1, bits shifted per config_en cycle
- MEM_SIZE, 1<<INPUTS, truth-table bits
- CONFIG_BITS, ceil((MEM_SIZE+2)/FRAME_WIDTH)*FRAME_WIDTH, shadow/active image width
- NUM_FRAMES, CONFIG_BITS/FRAME_WIDTH, frames per image

Ports:
- config_clk  in  1  sole clock
- reset  in  1  synchronous, active-low (asserted when 0)
- s  in  INPUTS  LUT select inputs
- ce  in  1  output-flop enable (registered mode only)
- z0  out  1  primary output
- z1  out  1  secondary output (fractured mode)
- config_en  in  1  shift one frame this cycle
- config_in  in  FRAME_WIDTH  incoming frame
- config_out  out  FRAME_WIDTH  top frame of shadow, for daisy-chaining
- config_commit  in  1  copy shadow to active
- config_done  out  1  one-cycle pulse when the final frame of an image is shifted
- config_loaded  out  1  full image held in shadow, awaiting commit

## Operation
- Image layout (active and shadow): [MEM_SIZE-1:0] truth table; [MEM_SIZE] frac_mode; [MEM_SIZE+1] reg_out; any higher bits are padding and ignored.
- Shift: on config_en, shadow <= {shadow[CONFIG_BITS-FRAME_WIDTH-1:0], config_in}. The first frame sent lands at the top; truth-table frame 0 is sent last.
- config_out = shadow[CONFIG_BITS-1 -: FRAME_WIDTH], combinational from the shadow register.
- Loader FSM has three states, with frame counter cnt of width $clog2(NUM_FRAMES+1):
  - IDLE (cnt=0): config_en → cnt=1 and LOADING. If NUM_FRAMES=1, go directly to LOADED and pulse done.
  - LOADING: config_en → cnt+1. On reaching NUM_FRAMES: cnt=0, pulse config_done, go to LOADED.
  - LOADED: config_commit → active<=shadow, go to IDLE. config_en → start a new image (cnt=1, LOADING), and the old image is abandoned.
- config_commit outside LOADED is ignored; active is unchanged.
- Simultaneous config_en and config_commit in LOADED: commit copies the pre-shift shadow, and the shift also occurs. Next state is LOADING with cnt=1.
- Function, with m = active truth table and L = s[INPUTS-2:0]:
  - frac_mode=0: f0=m[s], f1=0.
  - frac_mode=1: f0=m[{1'b0,L}], f1=m[{1'b1,L}].
- Output path:
  - reg_out=0: z0=f0, z1=f1 (combinational).
  - reg_out=1: z0=q0, z1=q1, where q0/q1 <= f0/f1 on cycles with ce=1 and hold otherwise.
  - q0/q1 keep updating in both modes.
- Reset (reset=0 at a clock edge), including mid-load or mid-commit:
  - shadow, active, q0, q1 and cnt clear to 0; state goes to IDLE.
  - Reset dominates config_en and config_commit.

## Timing
- Reset values: z0=0, z1=0, config_out=0, config_done=0, config_loaded=0.
- Function change appears on z the cycle after the commit edge (comb mode), or at the first ce edge after that (registered mode).
- s→z is combinational in comb mode. In registered mode, latency is 1 cycle from a ce edge.
- config_done is high for exactly the cycle after the final shifting edge. config_loaded is high from that same cycle until the commit edge.
- config_out reflects the shift one cycle after config_en. A chained downstream LUT sees a frame NUM_FRAMES cycles after it enters this one.

## Structure
- Package frac_lut_pkg holds:
  - enum cfg_state_t {IDLE, LOADING, LOADED};
  - localparam offset functions for the FRAC_BIT and REG_BIT positions, relative to MEM_SIZE.
- Sub-module lut_config_chain holds the shadow register, counter, FSM, done/loaded outputs and config_out. frac_lut holds the active register, decode muxes and output flops.

## Test plan
- INPUTS=4, FRAME_WIDTH=1 (18 frames): send reg_out=0, frac=0, then 0x8000 MSB-first, then commit → s=4'hF gives z0=1; s=4'hE gives z0=0; z1=0 throughout.
- Fractured mode: m[15:8]=0xE8, m[7:0]=0x96, frac=1, commit. L=3'b011 → z0=0, z1=1. L=3'b111 → z0=1, z1=1.
- Double-buffer: with AND4 active, load OR4 (0xFFFE). z0 at s=4'h1 stays 0 through all 18 frames and the done pulse, and becomes 1 the cycle after commit. A commit issued at frame 10 is ignored.
- Registered mode, FRAME_WIDTH=4 (5 frames, 20 bits): commit with reg_out=1. Change s with ce=0 → z0 holds. Assert ce → z0 updates on the following cycle.
- Reset after 10 frames: cnt=0 and config_loaded=0. A fresh 18-frame load then produces config_done exactly once. Reset asserted together with config_commit leaves active=0.
- Chaining: two instances, config_out→config_in, 36 frames → both load correct images. Both config_done pulses occur 18 cycles apart.
